gate_table_checker: RTL

- Self-contained truth-table sequencer and response checker for small combinational gate modules; it is the receiving end of the gate-test interface.
- Drives every input minterm of a DUT gate in ascending order, waits a programmable settle time, then samples the DUT output.
- Compares each sample against a parameterised expected truth table and reports pass/fail, mismatch count and the first failing minterm.
- Replaces hand-written `#1` stimulus blocks with a clocked, reusable checker instantiated beside each gate under test.

---
 rtl/gate_table_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gate_table_checker.sv
// Truth-table sequencer and response checker for a small combinational gate.
// Optional miss_map output enabled by defining GATE_TABLE_CHECKER_MISS_MAP_EN.
module gate_table_checker #(
  parameter int unsigned          N_IN   = 2,
  parameter logic [(2**N_IN)-1:0] EXPECT = 4'b0111,
  parameter int unsigned          SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic              resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_err_m,
  output logic              first_err_valid
`ifdef GATE_TABLE_CHECKER_MISS_MAP_EN
  ,
  output logic [(2**N_IN)-1:0] miss_map
`endif
);

  localparam int unsigned M  = 2**N_IN;
  localparam int unsigned CW = N_IN + 1;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [N_IN-1:0]   r_m, w_m_nxt;
  logic [SW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_pass, w_pass_nxt;
  logic [CW-1:0]     r_err_count, w_err_count_nxt;
  logic [N_IN-1:0]   r_first_err_m, w_first_err_m_nxt;
  logic              r_first_err_valid, w_first_err_valid_nxt;
  logic              w_mis;
  logic              w_last;
`ifdef GATE_TABLE_CHECKER_MISS_MAP_EN
  logic [M-1:0]      r_miss_map, w_miss_map_nxt;
`endif

  // Case inequality so an X/Z response is scored as a mismatch.
  assign w_mis  = (resp !== EXPECT[r_m]);
  assign w_last = (r_m == N_IN'(M - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_m               <= '0;
      r_cnt             <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_count       <= '0;
      r_first_err_m     <= '0;
      r_first_err_valid <= 1'b0;
`ifdef GATE_TABLE_CHECKER_MISS_MAP_EN
      r_miss_map        <= '0;
`endif
    end else begin
      r_state           <= w_state_nxt;
      r_m               <= w_m_nxt;
      r_cnt             <= w_cnt_nxt;
      r_busy            <= w_busy_nxt;
      r_done            <= w_done_nxt;
      r_pass            <= w_pass_nxt;
      r_err_count       <= w_err_count_nxt;
      r_first_err_m     <= w_first_err_m_nxt;
      r_first_err_valid <= w_first_err_valid_nxt;
`ifdef GATE_TABLE_CHECKER_MISS_MAP_EN
      r_miss_map        <= w_miss_map_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt           = r_state;
    w_m_nxt               = r_m;
    w_cnt_nxt             = r_cnt;
    w_busy_nxt            = r_busy;
    w_done_nxt            = 1'b0;
    w_pass_nxt            = r_pass;
    w_err_count_nxt       = r_err_count;
    w_first_err_m_nxt     = r_first_err_m;
    w_first_err_valid_nxt = r_first_err_valid;
`ifdef GATE_TABLE_CHECKER_MISS_MAP_EN
    w_miss_map_nxt        = r_miss_map;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt           = S_SETTLE;
          w_m_nxt               = '0;
          w_cnt_nxt             = SW'(SETTLE - 1);
          w_busy_nxt            = 1'b1;
          w_pass_nxt            = 1'b0;
          w_err_count_nxt       = '0;
          w_first_err_m_nxt     = '0;
          w_first_err_valid_nxt = 1'b0;
`ifdef GATE_TABLE_CHECKER_MISS_MAP_EN
          w_miss_map_nxt        = '0;
`endif
        end
      end
      S_SETTLE: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - SW'(1);
        else             w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_mis) begin
          w_err_count_nxt = r_err_count + CW'(1);
          if (!r_first_err_valid) begin
            w_first_err_m_nxt     = r_m;
            w_first_err_valid_nxt = 1'b1;
          end
`ifdef GATE_TABLE_CHECKER_MISS_MAP_EN
          w_miss_map_nxt[r_m] = 1'b1;
`endif
        end
        if (w_last) begin
          // Final verdict folds in this cycle's comparison.
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_pass_nxt  = (r_err_count == '0) && !w_mis;
        end else begin
          w_state_nxt = S_SETTLE;
          w_m_nxt     = r_m + N_IN'(1);
          w_cnt_nxt   = SW'(SETTLE - 1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign stim            = r_m;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign first_err_m     = r_first_err_m;
  assign first_err_valid = r_first_err_valid;
`ifdef GATE_TABLE_CHECKER_MISS_MAP_EN
  assign miss_map        = r_miss_map;
`endif

endmodule
